// File: rtl/run_detect_ctrl.sv
// Armed consecutive-ones run detector with start/done/ack handshake.
// Optional macro TIMEOUT_EN adds an ARMED-cycle wait limit that forces DONE with timeout=1.
module run_detect_ctrl #(
  parameter int RUN_LEN  = 2,
  parameter int CNT_W    = 4,
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             w,
  input  logic             ack,
  output logic             busy,
  output logic             z,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] run_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] HIT_AT  = CNT_W'(RUN_LEN - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt_n;
  logic             z_n;
  logic             hit;

`ifdef TIMEOUT_EN
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_n;
  logic              expired;

  assign expired = (state == S_ARMED) && (wait_cnt == WAIT_LAST);

  // Counts ARMED cycles; restarted on every arm so each attempt gets a full window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= timeout_n;
      if (state == S_IDLE && start) begin
        wait_cnt <= '0;
      end else if (state == S_ARMED) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = (MAX_WAIT > WAIT_W);
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      run_cnt <= '0;
      z       <= 1'b0;
    end else begin
      state   <= state_n;
      run_cnt <= cnt_n;
      z       <= z_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = run_cnt;
    z_n     = 1'b0;
    hit     = 1'b0;
`ifdef TIMEOUT_EN
    timeout_n = timeout;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_ARMED;
          cnt_n   = '0;
        end
      end
      S_ARMED: begin
        hit = w && (run_cnt == HIT_AT);
        if (hit) begin
          state_n = S_DONE;
          cnt_n   = RUN_MAX;
          z_n     = 1'b1;
        end else if (w) begin
          cnt_n = (run_cnt == RUN_MAX) ? RUN_MAX : run_cnt + 1'b1;
        end else begin
          cnt_n = '0;
        end
`ifdef TIMEOUT_EN
        // A hit on the limit edge takes precedence over the timeout.
        if (!hit && expired) begin
          state_n   = S_DONE;
          timeout_n = 1'b1;
        end
`endif
      end
      S_DONE: begin
        if (ack) begin
          state_n = S_IDLE;
`ifdef TIMEOUT_EN
          timeout_n = 1'b0;
`endif
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_run_detect_ctrl.sv
// Self-checking bench for run_detect_ctrl: four instances (RUN_LEN 1..4) share one stimulus stream.
// Directed scenario tasks use constant expectations; a randomized phase is checked against a behavioural model.
module tb_run_detect_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic w = 1'b0;
  logic ack = 1'b0;

  logic [3:0] busy_v, z_v, done_v, to_v;
  logic [3:0] cnt_v [4];

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_v;

  int rl [4] = '{1, 2, 3, 4};
  int mw [4] = '{16, 16, 16, 4};

  int m_st [4];
  int m_cnt [4];
  int m_wait [4];
  bit m_z [4];
  bit m_to [4];

  always #5 clk = ~clk;

  run_detect_ctrl #(.RUN_LEN(1), .CNT_W(4), .MAX_WAIT(16), .WAIT_W(5)) dut0 (
    .clk(clk), .reset(reset), .start(start), .w(w), .ack(ack),
    .busy(busy_v[0]), .z(z_v[0]), .done(done_v[0]), .timeout(to_v[0]), .run_cnt(cnt_v[0]));
  run_detect_ctrl #(.RUN_LEN(2), .CNT_W(4), .MAX_WAIT(16), .WAIT_W(5)) dut1 (
    .clk(clk), .reset(reset), .start(start), .w(w), .ack(ack),
    .busy(busy_v[1]), .z(z_v[1]), .done(done_v[1]), .timeout(to_v[1]), .run_cnt(cnt_v[1]));
  run_detect_ctrl #(.RUN_LEN(3), .CNT_W(4), .MAX_WAIT(16), .WAIT_W(5)) dut2 (
    .clk(clk), .reset(reset), .start(start), .w(w), .ack(ack),
    .busy(busy_v[2]), .z(z_v[2]), .done(done_v[2]), .timeout(to_v[2]), .run_cnt(cnt_v[2]));
  run_detect_ctrl #(.RUN_LEN(4), .CNT_W(4), .MAX_WAIT(4), .WAIT_W(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .w(w), .ack(ack),
    .busy(busy_v[3]), .z(z_v[3]), .done(done_v[3]), .timeout(to_v[3]), .run_cnt(cnt_v[3]));

  // Observed outputs of instance i packed as {busy, done, z, timeout, run_cnt}.
  function automatic logic [7:0] obs(input int i);
    return {busy_v[i], done_v[i], z_v[i], to_v[i], cnt_v[i]};
  endfunction

  function automatic logic [7:0] ex(input bit b, input bit d, input bit zz, input bit t, input int c);
    return {b, d, zz, t, 4'(c)};
  endfunction

  task automatic drive(input logic s, input logic wv, input logic a);
    start = s;
    w = wv;
    ack = a;
    @(posedge clk);
    #1;
    start = 1'b0;
    w = 1'b0;
    ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_st[i] = 0;
      m_cnt[i] = 0;
      m_wait[i] = 0;
      m_z[i] = 0;
      m_to[i] = 0;
    end
  endtask

  // Behavioural reference: 0 = idle, 1 = armed, 2 = done.
  task automatic model_step(input bit s, input bit wv, input bit a);
    for (int i = 0; i < 4; i++) begin
      case (m_st[i])
        0: begin
          m_z[i] = 0;
          if (s) begin
            m_st[i] = 1;
            m_cnt[i] = 0;
            m_wait[i] = 0;
          end
        end
        1: begin
          m_wait[i]++;
          if (wv && (m_cnt[i] + 1 == rl[i])) begin
            m_st[i] = 2;
            m_cnt[i] = rl[i];
            m_z[i] = 1;
          end else begin
            m_z[i] = 0;
            m_cnt[i] = wv ? ((m_cnt[i] + 1 > rl[i]) ? rl[i] : m_cnt[i] + 1) : 0;
`ifdef TIMEOUT_EN
            if (m_wait[i] >= mw[i]) begin
              m_st[i] = 2;
              m_to[i] = 1;
            end
`endif
          end
        end
        default: begin
          m_z[i] = 0;
          if (a) begin
            m_st[i] = 0;
            m_to[i] = 0;
          end
        end
      endcase
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs(i) !== 8'h00) begin
        n_fail++;
        $display("[TB] FAIL reset_init inst%0d: got %b want %b", i, obs(i), 8'h00);
      end
    end
    drive(1, 0, 0);
    exp_v = ex(1, 0, 0, 0, 0);
    n_checks++;
    if (obs(1) !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL reset_arm inst1: got %b want %b", obs(1), exp_v);
    end
    drive(0, 1, 0);
    exp_v = ex(1, 1, 1, 0, 1);
    n_checks++;
    if (obs(0) !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL runlen1_hit inst0: got %b want %b", obs(0), exp_v);
    end
    exp_v = ex(1, 0, 0, 0, 1);
    n_checks++;
    if (obs(1) !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL reset_run inst1: got %b want %b", obs(1), exp_v);
    end
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs(i) !== 8'h00) begin
        n_fail++;
        $display("[TB] FAIL reset_async inst%0d: got %b want %b", i, obs(i), 8'h00);
      end
    end
    #1;
    reset = 1'b0;
    drive(0, 0, 0);
    n_checks++;
    if (obs(1) !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL reset_idle inst1: got %b want %b", obs(1), 8'h00);
    end
    drive(1, 0, 0);
    exp_v = ex(1, 0, 0, 0, 0);
    n_checks++;
    if (obs(1) !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL reset_rearm inst1: got %b want %b", obs(1), exp_v);
    end
  endtask

  task automatic test_basic_hit();
    logic [7:0] want1 [4];
    logic [7:0] want0 [4];
    logic [2:0] stim [4];
    want1 = '{ex(1, 0, 0, 0, 1), ex(1, 1, 1, 0, 2), ex(1, 1, 0, 0, 2), ex(0, 0, 0, 0, 2)};
    want0 = '{ex(1, 1, 1, 0, 1), ex(1, 1, 0, 0, 1), ex(1, 1, 0, 0, 1), ex(0, 0, 0, 0, 1)};
    stim = '{3'b010, 3'b010, 3'b000, 3'b001};
    do_reset();
    drive(1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(stim[k][2], stim[k][1], stim[k][0]);
      n_checks++;
      if (obs(1) !== want1[k]) begin
        n_fail++;
        $display("[TB] FAIL basic_hit step%0d inst1: got %b want %b", k, obs(1), want1[k]);
      end
      n_checks++;
      if (obs(0) !== want0[k]) begin
        n_fail++;
        $display("[TB] FAIL basic_hit step%0d inst0: got %b want %b", k, obs(0), want0[k]);
      end
    end
  endtask

  task automatic test_broken_run();
    bit ws [6] = '{1, 1, 0, 1, 1, 1};
    int cs [6] = '{1, 2, 0, 1, 2, 3};
    do_reset();
    drive(1, 0, 0);
    for (int k = 0; k < 6; k++) begin
      drive(0, ws[k], 0);
      exp_v = ex(1, k == 5, k == 5, 0, cs[k]);
      n_checks++;
      if (obs(2) !== exp_v) begin
        n_fail++;
        $display("[TB] FAIL broken_run step%0d inst2: got %b want %b", k, obs(2), exp_v);
      end
    end
    drive(0, 1, 0);
    exp_v = ex(1, 1, 0, 0, 3);
    n_checks++;
    if (obs(2) !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL done_hold inst2: got %b want %b", obs(2), exp_v);
    end
  endtask

  task automatic test_handshake();
    do_reset();
    drive(1, 0, 0);
    drive(0, 1, 0);
    drive(0, 1, 0);
    exp_v = ex(1, 1, 1, 0, 2);
    n_checks++;
    if (obs(1) !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL hs_done inst1: got %b want %b", obs(1), exp_v);
    end
    drive(1, 0, 1);
    exp_v = ex(0, 0, 0, 0, 2);
    n_checks++;
    if (obs(1) !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL hs_start_ack inst1: got %b want %b", obs(1), exp_v);
    end
    drive(0, 0, 0);
    n_checks++;
    if (obs(1) !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL hs_no_rearm inst1: got %b want %b", obs(1), exp_v);
    end
    drive(1, 0, 0);
    exp_v = ex(1, 0, 0, 0, 0);
    n_checks++;
    if (obs(1) !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL hs_rearm inst1: got %b want %b", obs(1), exp_v);
    end
  endtask

  task automatic test_ignored_inputs();
    logic [2:0] stim [6];
    logic [7:0] want [6];
    stim = '{3'b011, 3'b100, 3'b001, 3'b010, 3'b011, 3'b110};
    want = '{ex(0, 0, 0, 0, 0), ex(1, 0, 0, 0, 0), ex(1, 0, 0, 0, 0),
             ex(1, 0, 0, 0, 1), ex(1, 0, 0, 0, 2), ex(1, 1, 1, 0, 3)};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(stim[k][2], stim[k][1], stim[k][0]);
      n_checks++;
      if (obs(2) !== want[k]) begin
        n_fail++;
        $display("[TB] FAIL ignored step%0d inst2: got %b want %b", k, obs(2), want[k]);
      end
    end
  endtask

  task automatic test_timeout();
    bit to_en;
`ifdef TIMEOUT_EN
    to_en = 1;
`else
    to_en = 0;
`endif
    do_reset();
    drive(1, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      drive(0, 0, 0);
      exp_v = (k >= 4 && to_en) ? ex(1, 1, 0, 1, 0) : ex(1, 0, 0, 0, 0);
      n_checks++;
      if (obs(3) !== exp_v) begin
        n_fail++;
        $display("[TB] FAIL timeout cycle%0d inst3: got %b want %b", k, obs(3), exp_v);
      end
    end
    drive(0, 0, 1);
    exp_v = to_en ? ex(0, 0, 0, 0, 0) : ex(1, 0, 0, 0, 0);
    n_checks++;
    if (obs(3) !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL timeout_ack inst3: got %b want %b", obs(3), exp_v);
    end
    do_reset();
    drive(1, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      drive(0, 1, 0);
      exp_v = (k == 4) ? ex(1, 1, 1, 0, 4) : ex(1, 0, 0, 0, k);
      n_checks++;
      if (obs(3) !== exp_v) begin
        n_fail++;
        $display("[TB] FAIL hit_vs_limit cycle%0d inst3: got %b want %b", k, obs(3), exp_v);
      end
    end
  endtask

  task automatic test_random();
    bit s, wv, a;
    do_reset();
    model_reset();
    for (int n = 0; n < 800; n++) begin
      s = ($urandom_range(0, 3) == 0);
      wv = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 4) == 0);
      start = s;
      w = wv;
      ack = a;
      @(posedge clk);
      model_step(s, wv, a);
      #1;
      for (int i = 0; i < 4; i++) begin
        exp_v = ex(m_st[i] != 0, m_st[i] == 2, m_z[i], m_to[i], m_cnt[i]);
        n_checks++;
        if (obs(i) !== exp_v) begin
          n_fail++;
          $display("[TB] FAIL random cyc%0d inst%0d: got %b want %b", n, i, obs(i), exp_v);
        end
      end
      if ($urandom_range(0, 63) == 0) begin
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 4; i++) begin
          n_checks++;
          if (obs(i) !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL random_reset cyc%0d inst%0d: got %b want %b", n, i, obs(i), 8'h00);
          end
        end
        #1;
        reset = 1'b0;
      end
    end
    start = 1'b0;
    w = 1'b0;
    ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_hit();
    test_broken_run();
    test_handshake();
    test_ignored_inputs();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
